alu_and_issue: RTL and testbench

ALU_AND_ISSUE -- requirements
Module: alu_and_issue

---
 rtl/alu_and_issue.sv | 103 ++++++++++
 tb/tb_alu_and_issue.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_and_issue.sv
// Operand issue and result capture for an adiabatic and16b array.
// Holds the array operands stable for LAT cycles, then captures and hands off the result.
module alu_and_issue #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LAT   = 2
) (
    input  logic             clkpos,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] drv_a,
    output logic [WIDTH-1:0] drv_b,
    input  logic [WIDTH-1:0] arr_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             busy,
    output logic [7:0]       op_cnt
);

    localparam int unsigned TW = 4;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic          accept;

    // A completing handshake frees the block, so DONE forwards res_ready upstream.
    always_comb begin
        in_ready = 1'b0;
        case (state)
            IDLE:    in_ready = 1'b1;
            DONE:    in_ready = res_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept = in_valid & in_ready;

    always_ff @(posedge clkpos or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            timer     <= '0;
            drv_a     <= '0;
            drv_b     <= '0;
            res_data  <= '0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            op_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        drv_a <= in_a;
                        drv_b <= in_b;
                        timer <= TIMER_LOAD;
                        state <= EVAL;
                        busy  <= 1'b1;
                    end
                end
                EVAL: begin
                    if (timer != '0) begin
                        timer <= timer - TW'(1);
                    end else begin
                        res_data  <= arr_out;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        op_cnt    <= op_cnt + 8'd1;
                        res_valid <= 1'b0;
                        // Back-to-back issue skips IDLE so the array sees no bubble.
                        if (accept) begin
                            drv_a <= in_a;
                            drv_b <= in_b;
                            timer <= TIMER_LOAD;
                            state <= EVAL;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_and_issue.sv
// Bench for alu_and_issue: a LAT=2 and a LAT=1 instance, each driving an a&b array model.
// Expected results are queued at issue and checked by an independent monitor.
module tb_alu_and_issue;

    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  in_valid, in_ready, res_valid, res_ready, busy;
    logic [15:0] in_a [2];
    logic [15:0] in_b [2];
    logic [15:0] drv_a [2];
    logic [15:0] drv_b [2];
    logic [15:0] arr_out [2];
    logic [15:0] res_data [2];
    logic [7:0]  op_cnt [2];

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;
    int lat [2] = '{2, 1};

    typedef struct {
        logic [15:0] d;
        int          at;
    } exp_t;

    exp_t q0 [$];
    exp_t q1 [$];
    logic [1:0] pv = 2'b00;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign arr_out[0] = drv_a[0] & drv_b[0];
    assign arr_out[1] = drv_a[1] & drv_b[1];

    alu_and_issue #(.WIDTH(16), .LAT(2)) u_dut0 (
        .clkpos(clk), .rstn(rstn),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_a(in_a[0]), .in_b(in_b[0]),
        .drv_a(drv_a[0]), .drv_b(drv_b[0]), .arr_out(arr_out[0]),
        .res_valid(res_valid[0]), .res_ready(res_ready[0]), .res_data(res_data[0]),
        .busy(busy[0]), .op_cnt(op_cnt[0])
    );

    alu_and_issue #(.WIDTH(16), .LAT(1)) u_dut1 (
        .clkpos(clk), .rstn(rstn),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_a(in_a[1]), .in_b(in_b[1]),
        .drv_a(drv_a[1]), .drv_b(drv_b[1]), .arr_out(arr_out[1]),
        .res_valid(res_valid[1]), .res_ready(res_ready[1]), .res_data(res_data[1]),
        .busy(busy[1]), .op_cnt(op_cnt[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every rising res_valid must match the oldest queued expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        for (int k = 0; k < 2; k++) begin
            if (res_valid[k] && !pv[k]) begin
                if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                    check($sformatf("spurious_result%0d", k), 32'd1, 32'd0);
                end else begin
                    if (k == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    check($sformatf("res_data%0d", k), 32'(res_data[k]), 32'(e.d));
                    check($sformatf("latency%0d", k), 32'(cyc), 32'(e.at));
                end
            end
            pv[k] = res_valid[k];
        end
    end

    // Offer a pair at the next falling edge and hold it until accepted.
    task automatic issue(input int k, input logic [15:0] a, input logic [15:0] b, input bit set_rr);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        in_valid[k] = 1'b1;
        in_a[k]     = a;
        in_b[k]     = b;
        if (set_rr) res_ready[k] = 1'b1;
        #1;
        while (!in_ready[k] && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready[k]) begin
            check($sformatf("issue_timeout%0d", k), 32'd0, 32'd1);
        end else begin
            e.d  = a & b;
            e.at = cyc + 1 + lat[k];
            if (k == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(negedge clk);
        in_valid[k] = 1'b0;
    endtask

    task automatic wait_valid(input int k);
        int n = 0;
        #1;
        while (!res_valid[k] && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check($sformatf("valid_timeout%0d", k), 32'(res_valid[k]), 32'd1);
    endtask

    task automatic wait_idle(input int k);
        int n = 0;
        @(negedge clk);
        #1;
        while (busy[k] && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check($sformatf("idle_timeout%0d", k), 32'(busy[k]), 32'd0);
    endtask

    task automatic check_reset_values(input int k, input string tag);
        check($sformatf("%s_in_ready%0d", tag, k),  32'(in_ready[k]),  32'd1);
        check($sformatf("%s_busy%0d", tag, k),      32'(busy[k]),      32'd0);
        check($sformatf("%s_res_valid%0d", tag, k), 32'(res_valid[k]), 32'd0);
        check($sformatf("%s_drv_a%0d", tag, k),     32'(drv_a[k]),     32'd0);
        check($sformatf("%s_drv_b%0d", tag, k),     32'(drv_b[k]),     32'd0);
        check($sformatf("%s_res_data%0d", tag, k),  32'(res_data[k]),  32'd0);
        check($sformatf("%s_op_cnt%0d", tag, k),    32'(op_cnt[k]),    32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [7:0] iv;
        rstn      = 1'b0;
        in_valid  = 2'b00;
        res_ready = 2'b00;
        for (int k = 0; k < 2; k++) begin
            in_a[k] = 16'h0;
            in_b[k] = 16'h0;
        end
        repeat (3) @(negedge clk);
        #1;
        check_reset_values(0, "por");
        check_reset_values(1, "por");

        // Release mid-cycle so the very next rising edge is the acceptance edge.
        @(posedge clk);
        #2;
        rstn = 1'b1;

        // Basic pass: F0F0 & 3C3C = 3030 after two edges.
        res_ready[0] = 1'b1;
        issue(0, 16'hF0F0, 16'h3C3C, 1'b0);
        #1;
        check("basic_drv_a", 32'(drv_a[0]), 32'h0000F0F0);
        check("basic_drv_b", 32'(drv_b[0]), 32'h00003C3C);
        check("basic_busy", 32'(busy[0]), 32'd1);
        wait_idle(0);
        check("basic_op_cnt", 32'(op_cnt[0]), 32'd1);
        check("basic_in_ready", 32'(in_ready[0]), 32'd1);

        // Backpressure: result 1234 & 0FF0 = 0230 held while a new pair is offered.
        res_ready[0] = 1'b0;
        issue(0, 16'h1234, 16'h0FF0, 1'b0);
        wait_valid(0);
        in_valid[0] = 1'b1;
        in_a[0]     = 16'hAAAA;
        in_b[0]     = 16'h0000;
        repeat (5) begin
            @(negedge clk);
            #1;
            check("bp_res_data", 32'(res_data[0]), 32'h00000230);
            check("bp_res_valid", 32'(res_valid[0]), 32'd1);
            check("bp_in_ready", 32'(in_ready[0]), 32'd0);
            check("bp_drv_a", 32'(drv_a[0]), 32'h00001234);
            check("bp_drv_b", 32'(drv_b[0]), 32'h00000FF0);
            check("bp_op_cnt", 32'(op_cnt[0]), 32'd1);
        end

        // Back-to-back: handshake and acceptance on one edge, next result 00FF.
        issue(0, 16'hFFFF, 16'h00FF, 1'b1);
        #1;
        check("b2b_op_cnt", 32'(op_cnt[0]), 32'd2);
        check("b2b_busy", 32'(busy[0]), 32'd1);
        check("b2b_res_valid", 32'(res_valid[0]), 32'd0);
        check("b2b_drv_a", 32'(drv_a[0]), 32'h0000FFFF);
        wait_idle(0);
        check("b2b_op_cnt_after", 32'(op_cnt[0]), 32'd3);

        // Reset one cycle after acceptance: everything clears, nothing is delivered.
        issue(0, 16'h5555, 16'hFFFF, 1'b0);
        #1;
        rstn = 1'b0;
        #1;
        check_reset_values(0, "mid_eval");
        q0.delete();
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("post_rst_op_cnt", 32'(op_cnt[0]), 32'd0);
        check("post_rst_busy", 32'(busy[0]), 32'd0);
        check("post_rst_res_valid", 32'(res_valid[0]), 32'd0);

        // LAT=1: 256 back-to-back operations, op_cnt wraps to zero.
        res_ready[1] = 1'b1;
        for (int i = 0; i < 256; i++) begin
            iv = 8'(i);
            issue(1, {iv, ~iv} ^ 16'hC35A, {~iv, iv}, 1'b0);
            if (i == 128 || i == 255) begin
                #1;
                check($sformatf("wrap_op_cnt_at_%0d", i), 32'(op_cnt[1]), 32'(i));
            end
        end
        wait_idle(1);
        check("wrap_op_cnt_final", 32'(op_cnt[1]), 32'd0);

        repeat (3) @(negedge clk);
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
